// File: rtl/adder2_seq_pkg.sv
// Shared types and elaboration helpers for the multi-digit adder sequencer.
package adder2_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    ADD,
    DONE
  } state_t;

  localparam int DIGIT_W = 2;

  // Digit-index width; a single-digit word still needs a one-bit index.
  function automatic int idx_width(input int digits);
    return (digits > 1) ? $clog2(digits) : 1;
  endfunction

  function automatic bit width_ok(input int width);
    return (width >= DIGIT_W) && ((width % DIGIT_W) == 0);
  endfunction

endpackage

// File: rtl/adder2_sequencer_if.sv
// Operand request and result return handshakes of the adder sequencer.
interface adder2_sequencer_if #(
  parameter int WIDTH = 8
);
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_a;
  logic [WIDTH-1:0] s_b;
  logic             s_carry;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_sum;
  logic             m_carry;
  logic             m_zero;

  modport master (
    output s_valid, s_a, s_b, s_carry, m_ready,
    input  s_ready, m_valid, m_sum, m_carry, m_zero
  );

  modport slave (
    input  s_valid, s_a, s_b, s_carry, m_ready,
    output s_ready, m_valid, m_sum, m_carry, m_zero
  );
endinterface

// File: rtl/adder2_sequencer_slice.sv
// Two-bit adder slice: latches addends on a write, presents sum/carry on a read.
module adder2_sequencer_slice (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       write,
  input  logic [1:0] addend0,
  input  logic [1:0] addend1,
  input  logic       rx_carryflag,
  output logic [1:0] tx_sum,
  output logic       tx_carryflag
);
  logic [1:0] addend0_q, addend0_d;
  logic [1:0] addend1_q, addend1_d;
  logic [2:0] total;

  always_comb begin
    addend0_d = addend0_q;
    addend1_d = addend1_q;
    if (enable && write) begin
      addend0_d = addend0;
      addend1_d = addend1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addend0_q <= 2'b00;
      addend1_q <= 2'b00;
    end else begin
      addend0_q <= addend0_d;
      addend1_q <= addend1_d;
    end
  end

  assign total = {1'b0, addend0_q} + {1'b0, addend1_q} + {2'b00, rx_carryflag};

  // Outputs are only meaningful during a read cycle; park them at zero otherwise.
  assign tx_sum       = (enable && !write) ? total[1:0] : 2'b00;
  assign tx_carryflag = (enable && !write) ? total[2]   : 1'b0;
endmodule

// File: rtl/adder2_sequencer.sv
// Multi-digit adder: ripples a 2-bit slice over the operands, LSB digit first.
module adder2_sequencer
  import adder2_seq_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic              aclk,
  input  logic              areset,
  adder2_sequencer_if.slave bus
);
  localparam int DIGITS = WIDTH / DIGIT_W;
  localparam int IDXW   = idx_width(DIGITS);
  localparam int SELW   = $clog2(WIDTH);
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DIGITS - 1);

  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("adder2_sequencer: WIDTH must be even and >= 2");
  end

  state_t           state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             zero_q, zero_d;
  logic             m_valid_q, m_valid_d;

  logic             slc_en, slc_wr, slc_rst_n;
  logic [1:0]       slc_sum;
  logic             slc_carry;
  logic [SELW-1:0]  digit_lsb;

  assign digit_lsb = SELW'({idx_q, 1'b0});
  assign slc_rst_n = ~areset;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    carry_d   = carry_q;
    zero_d    = zero_q;
    m_valid_d = m_valid_q;
    slc_en    = 1'b0;
    slc_wr    = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.s_valid) begin
          a_d     = bus.s_a;
          b_d     = bus.s_b;
          carry_d = bus.s_carry;
          idx_d   = '0;
          sum_d   = '0;
          state_d = LOAD;
        end
      end
      LOAD: begin
        slc_en  = 1'b1;
        slc_wr  = 1'b1;
        state_d = ADD;
      end
      ADD: begin
        slc_en                = 1'b1;
        sum_d[digit_lsb +: 2] = slc_sum;
        carry_d               = slc_carry;
        if (idx_q == LAST_IDX) begin
          zero_d    = ~|sum_d;
          m_valid_d = 1'b1;
          state_d   = DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
          state_d = LOAD;
        end
      end
      DONE: begin
        if (bus.m_ready) begin
          m_valid_d = 1'b0;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      sum_q     <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      a_q       <= a_d;
      b_q       <= b_d;
      sum_q     <= sum_d;
      carry_q   <= carry_d;
      zero_q    <= zero_d;
      m_valid_q <= m_valid_d;
    end
  end

  adder2_sequencer_slice u_slice (
    .clk          (aclk),
    .rst_n        (slc_rst_n),
    .enable       (slc_en),
    .write        (slc_wr),
    .addend0      (a_q[digit_lsb +: 2]),
    .addend1      (b_q[digit_lsb +: 2]),
    .rx_carryflag (carry_q),
    .tx_sum       (slc_sum),
    .tx_carryflag (slc_carry)
  );

  // Gated by reset so the requester never sees ready while the block is held.
  assign bus.s_ready = (state_q == IDLE) && !areset;
  assign bus.m_valid = m_valid_q;
  assign bus.m_sum   = sum_q;
  assign bus.m_carry = carry_q;
  assign bus.m_zero  = zero_q;
endmodule

// File: tb/tb_adder2_sequencer.sv
// Directed-vector and randomised check of adder2_sequencer at WIDTH=8 and WIDTH=2.
module tb_adder2_sequencer;
  logic clk    = 1'b0;
  logic areset = 1'b1;
  always #5 clk = ~clk;

  adder2_sequencer_if #(.WIDTH(8)) bus8 ();
  adder2_sequencer_if #(.WIDTH(2)) bus2 ();

  adder2_sequencer #(.WIDTH(8)) dut8 (.aclk(clk), .areset(areset), .bus(bus8));
  adder2_sequencer #(.WIDTH(2)) dut2 (.aclk(clk), .areset(areset), .bus(bus2));

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    int         stall;
    logic [7:0] sum;
    logic       carry;
    logic       zero;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input int stall, input logic [7:0] esum, input logic ecarry,
                         input logic ezero);
    int guard = 0;
    int lat   = 0;
    @(negedge clk);
    bus8.s_valid = 1'b1;
    bus8.s_a     = a;
    bus8.s_b     = b;
    bus8.s_carry = cin;
    while (!bus8.s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("w8_accept_wait", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    bus8.s_valid = 1'b0;
    bus8.s_a     = 8'($urandom);
    bus8.s_b     = 8'($urandom);
    bus8.s_carry = 1'($urandom);
    while (!bus8.m_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w8_latency", 32'(lat), 32'd8);
    check("w8_result", 32'({bus8.m_carry, bus8.m_zero, bus8.m_sum}), 32'({ecarry, ezero, esum}));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("w8_hold", 32'({bus8.m_valid, bus8.s_ready, bus8.m_carry, bus8.m_zero, bus8.m_sum}),
            32'({1'b1, 1'b0, ecarry, ezero, esum}));
    end
    bus8.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus8.m_ready = 1'b0;
    check("w8_after_hs", 32'({bus8.s_ready, bus8.m_valid}), 32'(2'b10));
    $display("[TB] w8 a=%02h b=%02h cin=%0d stall=%0d exp sum=%02h carry=%0d zero=%0d lat=%0d",
             a, b, cin, stall, esum, ecarry, ezero, lat);
  endtask

  task automatic run_op2(input logic [1:0] a, input logic [1:0] b, input logic cin,
                         input int stall, input logic [1:0] esum, input logic ecarry,
                         input logic ezero);
    int guard = 0;
    int lat   = 0;
    @(negedge clk);
    bus2.s_valid = 1'b1;
    bus2.s_a     = a;
    bus2.s_b     = b;
    bus2.s_carry = cin;
    while (!bus2.s_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("w2_accept_wait", 32'(guard < 50), 32'd1);
    @(posedge clk);
    #1;
    bus2.s_valid = 1'b0;
    bus2.s_a     = 2'($urandom);
    bus2.s_b     = 2'($urandom);
    bus2.s_carry = 1'($urandom);
    while (!bus2.m_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("w2_latency", 32'(lat), 32'd2);
    check("w2_result", 32'({bus2.m_carry, bus2.m_zero, bus2.m_sum}), 32'({ecarry, ezero, esum}));
    for (int i = 0; i < stall; i++) begin
      @(posedge clk);
      #1;
      check("w2_hold", 32'({bus2.m_valid, bus2.s_ready, bus2.m_carry, bus2.m_zero, bus2.m_sum}),
            32'({1'b1, 1'b0, ecarry, ezero, esum}));
    end
    bus2.m_ready = 1'b1;
    @(posedge clk);
    #1;
    bus2.m_ready = 1'b0;
    check("w2_after_hs", 32'({bus2.s_ready, bus2.m_valid}), 32'(2'b10));
    $display("[TB] w2 a=%0d b=%0d cin=%0d stall=%0d exp sum=%0d carry=%0d zero=%0d lat=%0d",
             a, b, cin, stall, esum, ecarry, ezero, lat);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t       vecs[8];
    logic [7:0] ra, rb;
    logic [1:0] qa, qb;
    logic       rc;
    logic [8:0] e8;
    logic [2:0] e2;
    logic       busy, acc, hs, saw_valid;
    int         n_acc, n_hs;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 0, 8'h00, 1'b0, 1'b1};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 1, 8'h00, 1'b1, 1'b1};
    vecs[2] = '{8'h5A, 8'h33, 1'b1, 5, 8'h8E, 1'b0, 1'b0};
    vecs[3] = '{8'hFF, 8'hFF, 1'b1, 0, 8'hFF, 1'b1, 1'b0};
    vecs[4] = '{8'h0F, 8'h01, 1'b0, 2, 8'h10, 1'b0, 1'b0};
    vecs[5] = '{8'h80, 8'h80, 1'b0, 0, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'hAA, 8'h55, 1'b0, 1, 8'hFF, 1'b0, 1'b0};
    vecs[7] = '{8'h00, 8'h00, 1'b1, 0, 8'h01, 1'b0, 1'b0};

    bus8.s_valid = 1'b0; bus8.s_a = '0; bus8.s_b = '0; bus8.s_carry = 1'b0; bus8.m_ready = 1'b0;
    bus2.s_valid = 1'b0; bus2.s_a = '0; bus2.s_b = '0; bus2.s_carry = 1'b0; bus2.m_ready = 1'b0;

    // Reset state while areset is held
    #12;
    check("w8_reset_state", 32'({bus8.s_ready, bus8.m_valid, bus8.m_carry, bus8.m_zero, bus8.m_sum}), 32'd0);
    check("w2_reset_state", 32'({bus2.s_ready, bus2.m_valid, bus2.m_carry, bus2.m_zero, bus2.m_sum}), 32'd0);
    @(negedge clk);
    areset = 1'b0;
    #1;
    check("reset_release_ready", 32'({bus8.s_ready, bus2.s_ready}), 32'(2'b11));

    foreach (vecs[i])
      run_op8(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].stall, vecs[i].sum, vecs[i].carry, vecs[i].zero);

    run_op2(2'd3, 2'd3, 1'b1, 1, 2'd3, 1'b1, 1'b0);
    run_op2(2'd0, 2'd0, 1'b0, 0, 2'd0, 1'b0, 1'b1);
    run_op2(2'd2, 2'd1, 1'b1, 2, 2'd0, 1'b1, 1'b1);

    // Abort during the second ADD (digit 1): E1=ADD0, E2=LOAD1, E3=ADD1
    @(negedge clk);
    bus8.s_valid = 1'b1; bus8.s_a = 8'h12; bus8.s_b = 8'h34; bus8.s_carry = 1'b0;
    @(posedge clk);
    #1;
    bus8.s_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    areset = 1'b1;
    #1;
    check("rst_mid_outputs", 32'({bus8.s_ready, bus8.m_valid, bus8.m_carry, bus8.m_zero, bus8.m_sum}), 32'd0);
    saw_valid = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
      saw_valid = saw_valid | bus8.m_valid;
    end
    @(negedge clk);
    areset = 1'b0;
    #1;
    check("rst_mid_ready", 32'(bus8.s_ready), 32'd1);
    repeat (20) begin
      @(posedge clk);
      #1;
      saw_valid = saw_valid | bus8.m_valid;
    end
    check("rst_mid_no_valid", 32'(saw_valid), 32'd0);
    $display("[TB] w8 reset mid-op a=12 b=34 aborted");
    run_op8(8'h0F, 8'h01, 1'b0, 0, 8'h10, 1'b0, 1'b0);

    // Continuous s_valid with an always-ready consumer
    @(negedge clk);
    bus8.s_a = 8'h21; bus8.s_b = 8'h10; bus8.s_carry = 1'b0;
    bus8.s_valid = 1'b1;
    bus8.m_ready = 1'b1;
    busy = 1'b0; n_acc = 0; n_hs = 0;
    for (int c = 0; c < 100; c++) begin
      check("hold_valid_ready", 32'(bus8.s_ready), 32'(!busy));
      acc = bus8.s_valid & bus8.s_ready;
      hs  = bus8.m_valid & bus8.m_ready;
      @(posedge clk);
      if (acc) begin busy = 1'b1; n_acc++; end
      if (hs)  begin busy = 1'b0; n_hs++;  end
      @(negedge clk);
    end
    bus8.s_valid = 1'b0;
    bus8.m_ready = 1'b0;
    check("hold_valid_accepts", 32'(n_acc), 32'd10);
    check("hold_valid_results", 32'(n_hs), 32'd10);
    $display("[TB] w8 continuous s_valid: %0d accepts, %0d results", n_acc, n_hs);

    for (int i = 0; i < 1000; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      e8 = {1'b0, ra} + {1'b0, rb} + 9'(rc);
      run_op8(ra, rb, rc, int'($urandom_range(0, 3)), e8[7:0], e8[8], e8[7:0] == 8'h00);
    end

    for (int i = 0; i < 1000; i++) begin
      qa = 2'($urandom);
      qb = 2'($urandom);
      rc = 1'($urandom);
      e2 = {1'b0, qa} + {1'b0, qb} + 3'(rc);
      run_op2(qa, qb, rc, int'($urandom_range(0, 3)), e2[1:0], e2[2], e2[1:0] == 2'b00);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
